// File: rtl/mc8051_int_ctrl.sv
// 8051-style interrupt controller: pending capture, two-level priority arbitration, nesting tracker.
// Latency: one cycle from a registered pending flag to int_req_n low, and one cycle from i_irq to o_pend.
// Backpressure: the request is held frozen until the core acks; new arbitration waits for ack release.
module mc8051_int_ctrl #(
  parameter int NUM_SRC = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] i_irq,
  input  logic [NUM_SRC-1:0] i_edge_mode,
  input  logic               i_ea,
  input  logic [NUM_SRC-1:0] i_ie,
  input  logic [NUM_SRC-1:0] i_ip,
  output logic               int_req_n,
  output logic [7:0]         int_so_num,
  input  logic               int_ack_n,
  input  logic               int_reti,
  output logic [NUM_SRC-1:0] o_pend,
  output logic [1:0]         o_in_service
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_ACK_WAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic               req_n_q, req_n_d;
  logic [2:0]         so_q, so_d;
  logic               lvl_q, lvl_d;     // 1 = latched request is high priority
  logic [1:0]         svc_q, svc_d;

  logic [NUM_SRC-1:0] elig;
  logic               hi_vld, lo_vld, cand_vld, cand_hi;
  logic [2:0]         hi_idx, lo_idx, cand_idx;
  logic               accept;

  assign accept = (state_q == ST_REQ) && !int_ack_n;

  // Arbitration: lowest index within each level; a candidate must outrank the in-service level
  always_comb begin
    elig     = pend_q & i_ie & {NUM_SRC{i_ea}};
    hi_vld   = 1'b0;
    lo_vld   = 1'b0;
    hi_idx   = 3'd0;
    lo_idx   = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i] && i_ip[i]) begin
        hi_vld = 1'b1;
        hi_idx = 3'(i);
      end
      if (elig[i] && !i_ip[i]) begin
        lo_vld = 1'b1;
        lo_idx = 3'(i);
      end
    end
    cand_vld = 1'b0;
    cand_hi  = 1'b1;
    cand_idx = hi_idx;
    if (hi_vld && !svc_q[1]) begin
      cand_vld = 1'b1;
      cand_hi  = 1'b1;
      cand_idx = hi_idx;
    end else if (lo_vld && (svc_q == 2'b00)) begin
      cand_vld = 1'b1;
      cand_hi  = 1'b0;
      cand_idx = lo_idx;
    end
  end

  // Handshake FSM: latch winner in IDLE, freeze it in REQ, wait for ack release in ACK_WAIT
  always_comb begin
    state_d = state_q;
    req_n_d = req_n_q;
    so_d    = so_q;
    lvl_d   = lvl_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_vld) begin
          state_d = ST_REQ;
          req_n_d = 1'b0;
          so_d    = cand_idx;
          lvl_d   = cand_hi;
        end
      end
      ST_REQ: begin
        // An ack in the same cycle as EA dropping still counts as accepted
        if (!int_ack_n) begin
          state_d = ST_ACK_WAIT;
          req_n_d = 1'b1;
        end else if (!i_ea) begin
          state_d = ST_IDLE;
          req_n_d = 1'b1;
        end
      end
      ST_ACK_WAIT: begin
        if (int_ack_n) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_n_d = 1'b1;
      end
    endcase
  end

  // Pending flags: edge sources latch rising edges (a new edge beats the accept clear), level sources follow i_irq
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i_edge_mode[i]) begin
        pend_d[i] = (i_irq[i] && !irq_prev_q[i]) ||
                    (pend_q[i] && !(accept && (so_q == 3'(i))));
      end else begin
        pend_d[i] = i_irq[i];
      end
    end
  end

  // In-service tracking: RETI pops the highest level first, then an accept pushes its level
  always_comb begin
    svc_d = svc_q;
    if (int_reti) begin
      if (svc_d[1]) svc_d[1] = 1'b0;
      else          svc_d[0] = 1'b0;
    end
    if (accept) begin
      if (lvl_q) svc_d[1] = 1'b1;
      else       svc_d[0] = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      irq_prev_q <= '0;
      pend_q     <= '0;
      req_n_q    <= 1'b1;
      so_q       <= 3'd0;
      lvl_q      <= 1'b0;
      svc_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= i_irq;
      pend_q     <= pend_d;
      req_n_q    <= req_n_d;
      so_q       <= so_d;
      lvl_q      <= lvl_d;
      svc_q      <= svc_d;
    end
  end

  assign int_req_n    = req_n_q;
  assign int_so_num   = {5'd0, so_q};
  assign o_pend       = pend_q;
  assign o_in_service = svc_q;

endmodule

// File: tb/tb_mc8051_int_ctrl.sv
// Directed bench for mc8051_int_ctrl: vector table plus hand-written handshake corner cases.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
// Every run is bounded by fixed cycle counts and a watchdog.
module tb_mc8051_int_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] irq, edge_m, ie, ip;
  logic       ea, ack_n, reti;
  logic       int_req_n;
  logic [7:0] int_so_num;
  logic [4:0] o_pend;
  logic [1:0] o_in_service;

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    logic [4:0] irq;
    logic [4:0] edge_m;
    logic       ea;
    logic [4:0] ie;
    logic [4:0] ip;
    logic       ack_n;
    logic       reti;
    logic       exp_req_n;
    logic [7:0] exp_so;
    logic [4:0] exp_pend;
    logic [1:0] exp_svc;
  } vec_t;

  vec_t vecs[$];

  mc8051_int_ctrl #(.NUM_SRC(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_irq        (irq),
    .i_edge_mode  (edge_m),
    .i_ea         (ea),
    .i_ie         (ie),
    .i_ip         (ip),
    .int_req_n    (int_req_n),
    .int_so_num   (int_so_num),
    .int_ack_n    (ack_n),
    .int_reti     (reti),
    .o_pend       (o_pend),
    .o_in_service (o_in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic req_n, input logic [7:0] so,
                           input logic [4:0] pend, input logic [1:0] svc);
    check({tag, " req_n"}, 8'(int_req_n), 8'(req_n));
    check({tag, " so_num"}, int_so_num, so);
    check({tag, " pend"}, 8'(o_pend), 8'(pend));
    check({tag, " in_svc"}, 8'(o_in_service), 8'(svc));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    irq = 5'h00; edge_m = 5'h00; ie = 5'h00; ip = 5'h00;
    ea = 1'b0; ack_n = 1'b1; reti = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic add_vec(input logic [4:0] v_irq, input logic [4:0] v_edge, input logic v_ea,
                         input logic [4:0] v_ie, input logic [4:0] v_ip, input logic v_ack_n,
                         input logic v_reti, input logic e_req_n, input logic [7:0] e_so,
                         input logic [4:0] e_pend, input logic [1:0] e_svc);
    vec_t v;
    v.irq = v_irq; v.edge_m = v_edge; v.ea = v_ea; v.ie = v_ie; v.ip = v_ip;
    v.ack_n = v_ack_n; v.reti = v_reti;
    v.exp_req_n = e_req_n; v.exp_so = e_so; v.exp_pend = e_pend; v.exp_svc = e_svc;
    vecs.push_back(v);
  endtask

  initial begin
    // Table: irq, edge, ea, ie, ip, ack_n, reti | req_n, so, pend, svc (values after the edge)
    // A: edge source 2 pulse, ack held two cycles
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 1, 0,  1, 8'd0, 5'h00, 2'b00);
    add_vec(5'h04, 5'h04, 1, 5'h04, 5'h00, 1, 0,  1, 8'd0, 5'h04, 2'b00);
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 1, 0,  0, 8'd2, 5'h04, 2'b00);
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 0, 0,  1, 8'd2, 5'h00, 2'b01);
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 0, 0,  1, 8'd2, 5'h00, 2'b01);
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 1, 0,  1, 8'd2, 5'h00, 2'b01);
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 1, 1,  1, 8'd2, 5'h00, 2'b00);
    add_vec(5'h00, 5'h04, 1, 5'h04, 5'h00, 1, 0,  1, 8'd2, 5'h00, 2'b00);
    // B: low 3 in service, high 1 nests, low 4 waits for two RETIs
    add_vec(5'h08, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd2, 5'h08, 2'b00);
    add_vec(5'h08, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  0, 8'd3, 5'h08, 2'b00);
    add_vec(5'h08, 5'h00, 1, 5'h1F, 5'h02, 0, 0,  1, 8'd3, 5'h08, 2'b01);
    add_vec(5'h08, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd3, 5'h08, 2'b01);
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd3, 5'h0A, 2'b01);
    add_vec(5'h1A, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  0, 8'd1, 5'h1A, 2'b01);
    add_vec(5'h1A, 5'h00, 1, 5'h1F, 5'h02, 0, 0,  1, 8'd1, 5'h1A, 2'b11);
    add_vec(5'h1A, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd1, 5'h1A, 2'b11);
    add_vec(5'h10, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd1, 5'h10, 2'b11);
    add_vec(5'h10, 5'h00, 1, 5'h1F, 5'h02, 1, 1,  1, 8'd1, 5'h10, 2'b01);
    add_vec(5'h10, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd1, 5'h10, 2'b01);
    add_vec(5'h10, 5'h00, 1, 5'h1F, 5'h02, 1, 1,  1, 8'd1, 5'h10, 2'b00);
    add_vec(5'h10, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  0, 8'd4, 5'h10, 2'b00);
    add_vec(5'h10, 5'h00, 1, 5'h1F, 5'h02, 0, 0,  1, 8'd4, 5'h10, 2'b01);
    add_vec(5'h00, 5'h00, 1, 5'h1F, 5'h02, 1, 0,  1, 8'd4, 5'h00, 2'b01);
    add_vec(5'h00, 5'h00, 1, 5'h1F, 5'h02, 1, 1,  1, 8'd4, 5'h00, 2'b00);
    // C: sources 1 and 3 together; low tie goes to 1, raising ip[3] makes 3 win
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h00, 1, 0,  1, 8'd4, 5'h0A, 2'b00);
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h00, 1, 0,  0, 8'd1, 5'h0A, 2'b00);
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h00, 0, 0,  1, 8'd1, 5'h0A, 2'b01);
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h08, 1, 1,  1, 8'd1, 5'h0A, 2'b00);
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h08, 1, 0,  0, 8'd3, 5'h0A, 2'b00);
    add_vec(5'h0A, 5'h00, 1, 5'h1F, 5'h08, 0, 0,  1, 8'd3, 5'h0A, 2'b10);
    add_vec(5'h00, 5'h00, 1, 5'h1F, 5'h08, 1, 0,  1, 8'd3, 5'h00, 2'b10);
    add_vec(5'h00, 5'h00, 1, 5'h1F, 5'h08, 1, 1,  1, 8'd3, 5'h00, 2'b00);
    // D: ie/ip change in REQ is ignored, EA drop withdraws, ack in IDLE is ignored
    add_vec(5'h01, 5'h00, 1, 5'h1F, 5'h00, 1, 0,  1, 8'd3, 5'h01, 2'b00);
    add_vec(5'h01, 5'h00, 1, 5'h1F, 5'h00, 1, 0,  0, 8'd0, 5'h01, 2'b00);
    add_vec(5'h01, 5'h00, 1, 5'h00, 5'h1F, 1, 0,  0, 8'd0, 5'h01, 2'b00);
    add_vec(5'h01, 5'h00, 0, 5'h1F, 5'h00, 1, 0,  1, 8'd0, 5'h01, 2'b00);
    add_vec(5'h01, 5'h00, 0, 5'h1F, 5'h00, 0, 0,  1, 8'd0, 5'h01, 2'b00);
    add_vec(5'h01, 5'h00, 1, 5'h1F, 5'h00, 1, 0,  0, 8'd0, 5'h01, 2'b00);
    add_vec(5'h01, 5'h00, 1, 5'h1F, 5'h00, 0, 0,  1, 8'd0, 5'h01, 2'b01);
    add_vec(5'h00, 5'h00, 1, 5'h1F, 5'h00, 1, 0,  1, 8'd0, 5'h00, 2'b01);
    add_vec(5'h00, 5'h00, 1, 5'h1F, 5'h00, 1, 1,  1, 8'd0, 5'h00, 2'b00);

    // Reset with all level sources requesting
    reset_n = 1'b0;
    irq = 5'h1F; edge_m = 5'h00; ie = 5'h1F; ip = 5'h00;
    ea = 1'b1; ack_n = 1'b1; reti = 1'b0;
    tick();
    tick();
    check_all("in_reset", 1'b1, 8'd0, 5'h00, 2'b00);
    reset_n = 1'b1;
    tick();
    check_all("rel_edge1", 1'b1, 8'd0, 5'h1F, 2'b00);
    tick();
    check_all("rel_edge2", 1'b0, 8'd0, 5'h1F, 2'b00);
    // Asynchronous reset while in REQ
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 1'b1, 8'd0, 5'h00, 2'b00);
    do_reset();

    foreach (vecs[i]) begin
      irq = vecs[i].irq; edge_m = vecs[i].edge_m; ea = vecs[i].ea;
      ie = vecs[i].ie; ip = vecs[i].ip; ack_n = vecs[i].ack_n; reti = vecs[i].reti;
      tick();
      check_all($sformatf("row%0d", i), vecs[i].exp_req_n, vecs[i].exp_so,
                vecs[i].exp_pend, vecs[i].exp_svc);
    end

    // REQ is frozen on source 4 when high source 0 arrives; blocking afterwards depends on source 4's level
    for (int v = 0; v < 2; v++) begin
      do_reset();
      ie = 5'h1F; ea = 1'b1; ip = (v == 1) ? 5'h11 : 5'h01;
      irq = 5'h10;
      tick();
      tick();
      check($sformatf("frz%0d so_first", v), int_so_num, 8'd4);
      irq = 5'h11;
      tick();
      tick();
      check($sformatf("frz%0d so_held", v), int_so_num, 8'd4);
      check($sformatf("frz%0d req_held", v), 8'(int_req_n), 8'd0);
      ack_n = 1'b0;
      tick();
      check($sformatf("frz%0d svc", v), 8'(o_in_service), (v == 1) ? 8'd2 : 8'd1);
      ack_n = 1'b1;
      irq = 5'h01;
      tick();
      tick();
      check($sformatf("frz%0d next_req", v), 8'(int_req_n), (v == 1) ? 8'd1 : 8'd0);
      check($sformatf("frz%0d next_so", v), int_so_num, (v == 1) ? 8'd4 : 8'd0);
    end

    // Edge flag re-armed by a rising edge on the accepting cycle
    do_reset();
    edge_m = 5'h04; ie = 5'h04; ea = 1'b1;
    irq = 5'h04;
    tick();
    irq = 5'h00;
    tick();
    check_all("edge_req", 1'b0, 8'd2, 5'h04, 2'b00);
    irq = 5'h04; ack_n = 1'b0;
    tick();
    check_all("edge_ack_set", 1'b1, 8'd2, 5'h04, 2'b01);
    irq = 5'h00; ack_n = 1'b1; reti = 1'b1;
    tick();
    check_all("edge_wait", 1'b1, 8'd2, 5'h04, 2'b00);
    reti = 1'b0;
    tick();
    check_all("edge_rereq", 1'b0, 8'd2, 5'h04, 2'b00);
    reset_n = 1'b0;
    #1;
    check_all("edge_async_rst", 1'b1, 8'd0, 5'h00, 2'b00);

    // RETI and ack on the same cycle: pop low, then push high
    do_reset();
    ie = 5'h1F; ea = 1'b1; ip = 5'h02;
    irq = 5'h08;
    tick();
    tick();
    ack_n = 1'b0;
    tick();
    ack_n = 1'b1; irq = 5'h02;
    tick();
    tick();
    check_all("nest_req", 1'b0, 8'd1, 5'h02, 2'b01);
    ack_n = 1'b0; reti = 1'b1;
    tick();
    check_all("reti_ack", 1'b1, 8'd1, 5'h02, 2'b10);
    ack_n = 1'b1; reti = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
